// File: rtl/gate_exerciser.sv
// gate_exerciser
// Sweeps the four {a,b} input vectors of a two-input gate. Each vector is
// held for SETTLE_CYCLES cycles plus one sample cycle. The gate output is
// compared against the EXPECT truth table, and per-vector mismatches are
// collected in fail_vec.
//
// Ports
//   clk      : rising-edge clock for all logic
//   rst      : synchronous active-high reset
//   start    : request one sweep; only sampled while idle
//   a_out    : gate input a (vector index bit 1), 0 when idle
//   b_out    : gate input b (vector index bit 0), 0 when idle
//   c_in     : gate output under test, same clock domain
//   busy     : sweep in progress, DONE cycle included
//   done     : one-cycle pulse at sweep completion
//   pass     : last completed sweep had no mismatches
//   fail_vec : bit i set when vector i mismatched
//
// state  | meaning
// IDLE   | outputs parked at 0, waiting for start
// SETTLE | current vector driven, counting settle cycles
// SAMPLE | c_in compared against EXPECT[idx]
// DONE   | done pulse, pass updated from fail_vec
module gate_exerciser #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [3:0] EXPECT        = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       c_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    fail_vec_q, fail_vec_d;
    logic          pass_q, pass_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          a_out_q, a_out_d;
    logic          b_out_q, b_out_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        fail_vec_d = fail_vec_q;
        pass_d     = pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d      = 2'd0;
                    cnt_d      = '0;
                    fail_vec_d = 4'b0000;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                fail_vec_d[idx_q] = c_in ^ EXPECT[idx_q];
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                pass_d  = (fail_vec_q == 4'b0000);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up
        // with the state they describe, without a cycle of lag.
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        a_out_d = busy_d & idx_d[1];
        b_out_d = busy_d & idx_d[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            fail_vec_q <= 4'b0000;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            a_out_q    <= 1'b0;
            b_out_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            fail_vec_q <= fail_vec_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            a_out_q    <= a_out_d;
            b_out_q    <= b_out_d;
        end
    end

    assign a_out    = a_out_q;
    assign b_out    = b_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser. Three instances run at different times:
//   u0: default parameters (AND expected), gate is AND or tied high.
//   u1: EXPECT = XOR with an AND gate attached.
//   u2: SETTLE_CYCLES = 1 with an AND gate attached.
// The stimulus pushes expected done events and per-cycle checkpoints into
// queues. A monitor process pops them and compares against the DUT outputs.
module tb_gate_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst;
    logic start0, start1, start2;
    logic tie1;

    logic a0, b0, c0, busy0, done0, pass0;
    logic a1, b1, c1, busy1, done1, pass1;
    logic a2, b2, c2, busy2, done2, pass2;
    logic [3:0] fv0, fv1, fv2;

    assign c0 = tie1 ? 1'b1 : (a0 & b0);
    assign c1 = a1 & b1;
    assign c2 = a2 & b2;

    gate_exerciser u0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0),
        .c_in(c0), .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fv0)
    );

    gate_exerciser #(.EXPECT(4'b0110)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
        .c_in(c1), .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1)
    );

    gate_exerciser #(.SETTLE_CYCLES(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2),
        .c_in(c2), .busy(busy2), .done(done2), .pass(pass2), .fail_vec(fv2)
    );

    logic [2:0] done_v;
    logic [2:0] pass_v;
    logic [3:0] fv_w [3];
    assign done_v  = {done2, done1, done0};
    assign pass_v  = {pass2, pass1, pass0};
    assign fv_w[0] = fv0;
    assign fv_w[1] = fv1;
    assign fv_w[2] = fv2;

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] fv;
        logic       pass;
    } done_t;

    // Checkpoint value for u0: {busy, a, b, pass, fail_vec}
    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ck_t;

    done_t done_q[$];
    ck_t   ck_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic pass_pend [3];
    logic pass_exp  [3];

    task automatic push_done(input int c, input int d, input logic [3:0] fv, input logic p);
        done_t e;
        e.cyc = c; e.dut = d; e.fv = fv; e.pass = p;
        done_q.push_back(e);
    endtask

    task automatic push_ck(input int c, input logic [7:0] v);
        ck_t e;
        e.cyc = c; e.val = v;
        ck_q.push_back(e);
    endtask

    // Expected trace of one u0 sweep (S = 4) accepted at edge T.
    // m = final mismatch bits, pb/pa = pass before/after the sweep.
    task automatic exp_sweep0(input int t, input logic [3:0] m, input logic pb, input logic pa);
        logic [3:0] mk;
        logic [1:0] kk;
        for (int k = 0; k < 4; k++) begin
            mk = 4'((1 << k) - 1);
            kk = 2'(k);
            push_ck(t + k * 5 + 1, {1'b1, kk, pb, m & mk});
            push_ck(t + k * 5 + 5, {1'b1, kk, pb, m & mk});
        end
        push_done(t + 21, 0, m, pa);
        push_ck(t + 22, {1'b0, 2'b00, pa, m});
    endtask

    task automatic set_start(input int d, input logic v);
        case (d)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic pulse(input int d);
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor
    initial begin
        done_t e;
        ck_t   k;
        logic [7:0] act;
        for (int d = 0; d < 3; d++) begin
            pass_pend[d] = 1'b0;
            pass_exp[d]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (pass_pend[d]) begin
                    n_tests++;
                    if (pass_v[d] !== pass_exp[d]) begin
                        n_fail++;
                        $display("FAIL pass dut%0d cycle %0d: got %b expected %b", d, cyc, pass_v[d], pass_exp[d]);
                    end
                    pass_pend[d] = 1'b0;
                end
            end
            for (int d = 0; d < 3; d++) begin
                if (done_v[d] === 1'b1) begin
                    n_tests++;
                    if (done_q.size() == 0 || done_q[0].dut != d) begin
                        n_fail++;
                        $display("FAIL done dut%0d: unexpected pulse at cycle %0d", d, cyc);
                    end else begin
                        e = done_q.pop_front();
                        if (e.cyc != cyc || fv_w[d] !== e.fv) begin
                            n_fail++;
                            $display("FAIL done dut%0d: cycle %0d fail_vec %b, expected cycle %0d fail_vec %b",
                                     d, cyc, fv_w[d], e.cyc, e.fv);
                        end
                        pass_pend[d] = 1'b1;
                        pass_exp[d]  = e.pass;
                    end
                end
            end
            while (ck_q.size() > 0 && ck_q[0].cyc <= cyc) begin
                k = ck_q.pop_front();
                n_tests++;
                act = {busy0, a0, b0, pass0, fv0};
                if (k.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL checkpoint: cycle %0d missed, now at %0d", k.cyc, cyc);
                end else if (act !== k.val) begin
                    n_fail++;
                    $display("FAIL checkpoint cycle %0d: {busy,a,b,pass,fail_vec} got %b expected %b",
                             cyc, act, k.val);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int t;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        tie1   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_ck(cyc + 1, 8'b0);
        @(negedge clk);

        // XOR expected, AND attached
        @(negedge clk); t = cyc;
        push_done(t + 21, 1, 4'b1110, 1'b0);
        pulse(1);
        wait_until(t + 24);

        // SETTLE_CYCLES = 1
        @(negedge clk); t = cyc;
        push_done(t + 9, 2, 4'b0000, 1'b1);
        pulse(2);
        wait_until(t + 12);

        // AND attached, default parameters
        @(negedge clk); t = cyc;
        exp_sweep0(t, 4'b0000, 1'b0, 1'b1);
        pulse(0);
        wait_until(t + 24);

        // c_in tied high
        tie1 = 1'b1;
        @(negedge clk); t = cyc;
        exp_sweep0(t, 4'b0111, 1'b1, 1'b0);
        pulse(0);
        wait_until(t + 24);

        // Back to AND; pass stays 0 until DONE
        tie1 = 1'b0;
        @(negedge clk); t = cyc;
        exp_sweep0(t, 4'b0000, 1'b0, 1'b1);
        pulse(0);
        wait_until(t + 24);

        // Extra start pulses in cycles 3 and 15 are ignored
        @(negedge clk); t = cyc;
        exp_sweep0(t, 4'b0000, 1'b1, 1'b1);
        pulse(0);
        wait_until(t + 3);
        pulse(0);
        wait_until(t + 15);
        pulse(0);
        wait_until(t + 24);

        // start held high: back-to-back sweeps, each restart one idle cycle after DONE
        @(negedge clk); t = cyc;
        exp_sweep0(t,      4'b0000, 1'b1, 1'b1);
        exp_sweep0(t + 22, 4'b0000, 1'b1, 1'b1);
        exp_sweep0(t + 44, 4'b0000, 1'b1, 1'b1);
        start0 = 1'b1;
        wait_until(t + 49);
        start0 = 1'b0;
        wait_until(t + 70);

        // Reset in cycle 12 aborts the sweep without a done pulse
        @(negedge clk); t = cyc;
        push_ck(t + 1,  {1'b1, 2'b00, 1'b1, 4'b0000});
        push_ck(t + 11, {1'b1, 2'b10, 1'b1, 4'b0000});
        push_ck(t + 13, 8'b0);
        pulse(0);
        wait_until(t + 12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_until(t + 30);

        // Fresh sweep after reset
        @(negedge clk); t = cyc;
        exp_sweep0(t, 4'b0000, 1'b0, 1'b1);
        pulse(0);
        wait_until(t + 24);

        for (int i = 0; i < 100 && (ck_q.size() > 0 || done_q.size() > 0); i++) @(negedge clk);
        if (ck_q.size() > 0 || done_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d checkpoints and %0d done events still pending", ck_q.size(), done_q.size());
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
